// File: rtl/spu_pipe_arbiter.sv
// spu_pipe_arbiter: round-robin issue arbiter for a shared fixed-latency SPU pipeline,
// with a tag pipeline routing results back and per-requester result-buffer credits.
module spu_pipe_arbiter #(
    parameter int N = 4,
    parameter int LATENCY = 3,
    parameter int CREDITS = 2,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cke,
    input  logic [N-1:0]     s_req,
    output logic [N-1:0]     s_grant,
    input  logic [N-1:0]     s_credit_ret,
    output logic             m_issue_valid,
    output logic [SEL_W-1:0] m_issue_sel,
    output logic [N-1:0]     m_result_valid,
    output logic [N*4-1:0]   m_credit,
    output logic             m_error
);
    if (LATENCY < 1) begin : g_bad_latency
        $error("spu_pipe_arbiter: LATENCY must be >= 1");
    end

    logic [SEL_W-1:0] r_ptr;
    logic [3:0]       r_credit [N];
    logic             r_error;
    logic [LATENCY-1:0] r_tv;
    logic [SEL_W-1:0] r_ti [LATENCY];

    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_off;
    logic [SEL_W:0]   w_sum;
    logic [SEL_W-1:0] w_win;
    logic             w_any;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_elig[i] = s_req[i] & (r_credit[i] != 4'd0) & cke & reset_n;
            m_credit[4*i +: 4] = r_credit[i];
        end
    end

    // Rotate eligibility so the search always starts at bit 0 of w_rot.
    assign w_rot = N'({w_elig, w_elig} >> r_ptr);

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (w_rot[k]) w_off = SEL_W'(k);
    end

    assign w_any = |w_elig;
    assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win = w_any ? SEL_W'(w_sum >= (SEL_W+1)'(N) ? w_sum - (SEL_W+1)'(N) : w_sum) : '0;

    assign s_grant        = w_any ? N'(1) << w_win : '0;
    assign m_issue_valid  = w_any;
    assign m_issue_sel    = w_win;
    assign m_result_valid = r_tv[LATENCY-1] ? N'(1) << r_ti[LATENCY-1] : '0;
    assign m_error        = r_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_tv  <= '0;
            for (int k = 0; k < LATENCY; k++) r_ti[k] <= '0;
        end else if (cke) begin
            if (w_any) r_ptr <= (w_win == SEL_W'(N - 1)) ? '0 : w_win + 1'b1;
            r_tv[0] <= m_issue_valid;
            r_ti[0] <= m_issue_sel;
            for (int k = 1; k < LATENCY; k++) begin
                r_tv[k] <= r_tv[k-1];
                r_ti[k] <= r_ti[k-1];
            end
        end
    end

    // Credits track buffer occupancy every edge, regardless of cke.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
            for (int i = 0; i < N; i++) r_credit[i] <= 4'(CREDITS);
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s_grant[i] && !s_credit_ret[i])
                    r_credit[i] <= r_credit[i] - 4'd1;
                else if (!s_grant[i] && s_credit_ret[i]) begin
                    if (r_credit[i] == 4'(CREDITS)) r_error <= 1'b1;
                    else r_credit[i] <= r_credit[i] + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_spu_pipe_arbiter.sv
// tb_spu_pipe_arbiter: directed tests of arbitration, tag routing, cke stall, credits and reset.
module tb_spu_pipe_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cke = 1'b1;
    logic [3:0]  s_req = '0;
    logic [3:0]  s_grant;
    logic [3:0]  s_credit_ret = '0;
    logic        m_issue_valid;
    logic [1:0]  m_issue_sel;
    logic [3:0]  m_result_valid;
    logic [15:0] m_credit;
    logic        m_error;
    int errors = 0;
    int checks = 0;

    spu_pipe_arbiter #(.N(4), .LATENCY(3), .CREDITS(2)) dut (
        .clk(clk), .reset_n(reset_n), .cke(cke), .s_req(s_req), .s_grant(s_grant),
        .s_credit_ret(s_credit_ret), .m_issue_valid(m_issue_valid), .m_issue_sel(m_issue_sel),
        .m_result_valid(m_result_valid), .m_credit(m_credit), .m_error(m_error)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] req, input logic [3:0] ret, input logic en);
        s_req = req;
        s_credit_ret = ret;
        cke = en;
        #2;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        s_req = '0;
        s_credit_ret = '0;
        cke = 1'b1;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        set_in(4'hF, 4'h0, 1'b1);
        tick();
        checks++; if (s_grant !== 4'h0) begin errors++; $display("FAIL reset grant got=%b exp=0000", s_grant); end
        checks++; if (m_issue_valid !== 1'b0) begin errors++; $display("FAIL reset issue_valid got=%b exp=0", m_issue_valid); end
        checks++; if (m_issue_sel !== 2'd0) begin errors++; $display("FAIL reset issue_sel got=%0d exp=0", m_issue_sel); end
        checks++; if (m_result_valid !== 4'h0) begin errors++; $display("FAIL reset result got=%b exp=0000", m_result_valid); end
        checks++; if (m_credit !== 16'h2222) begin errors++; $display("FAIL reset credit got=%h exp=2222", m_credit); end
        checks++; if (m_error !== 1'b0) begin errors++; $display("FAIL reset error got=%b exp=0", m_error); end
        s_req = '0;
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        logic [3:0] eg, er, ec;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_in(4'b0001, 4'h0, 1'b1);
            eg = (c < 2) ? 4'b0001 : 4'b0000;
            er = (c == 3 || c == 4) ? 4'b0001 : 4'b0000;
            ec = (c == 0) ? 4'd2 : (c == 1) ? 4'd1 : 4'd0;
            checks++; if (s_grant !== eg) begin errors++; $display("FAIL single grant c=%0d got=%b exp=%b", c, s_grant, eg); end
            checks++; if (m_result_valid !== er) begin errors++; $display("FAIL single result c=%0d got=%b exp=%b", c, m_result_valid, er); end
            checks++; if (m_credit[3:0] !== ec) begin errors++; $display("FAIL single credit c=%0d got=%0d exp=%0d", c, m_credit[3:0], ec); end
            tick();
        end
        set_in(4'b0001, 4'b0001, 1'b1);
        checks++; if (s_grant !== 4'b0000) begin errors++; $display("FAIL single grant_at_ret got=%b exp=0000", s_grant); end
        tick();
        set_in(4'b0001, 4'b0000, 1'b1);
        checks++; if (s_grant !== 4'b0001) begin errors++; $display("FAIL single grant_resume got=%b exp=0001", s_grant); end
        tick();
    endtask

    task automatic test_round_robin;
        logic [3:0] eg, er;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            er = (c >= 3) ? 4'(1 << ((c - 3) % 4)) : 4'h0;
            eg = 4'(1 << (c % 4));
            set_in(4'hF, er, 1'b1);
            checks++; if (s_grant !== eg) begin errors++; $display("FAIL rr grant c=%0d got=%b exp=%b", c, s_grant, eg); end
            checks++; if (m_issue_sel !== 2'(c % 4)) begin errors++; $display("FAIL rr sel c=%0d got=%0d exp=%0d", c, m_issue_sel, c % 4); end
            checks++; if (m_issue_valid !== 1'b1) begin errors++; $display("FAIL rr issue_valid c=%0d got=%b exp=1", c, m_issue_valid); end
            checks++; if (m_result_valid !== er) begin errors++; $display("FAIL rr result c=%0d got=%b exp=%b", c, m_result_valid, er); end
            tick();
        end
        for (int c = 8; c < 11; c++) begin
            er = 4'(1 << ((c - 3) % 4));
            set_in(4'h0, er, 1'b1);
            checks++; if (m_result_valid !== er) begin errors++; $display("FAIL rr drain_result c=%0d got=%b exp=%b", c, m_result_valid, er); end
            tick();
        end
        set_in(4'h0, 4'h0, 1'b1);
        checks++; if (m_credit !== 16'h2222) begin errors++; $display("FAIL rr credit got=%h exp=2222", m_credit); end
        checks++; if (m_error !== 1'b0) begin errors++; $display("FAIL rr error got=%b exp=0", m_error); end
        tick();
    endtask

    task automatic test_cke_stall;
        do_reset();
        set_in(4'b0100, 4'h0, 1'b1);
        checks++; if (s_grant !== 4'b0100) begin errors++; $display("FAIL stall issue_grant got=%b exp=0100", s_grant); end
        checks++; if (m_issue_sel !== 2'd2) begin errors++; $display("FAIL stall issue_sel got=%0d exp=2", m_issue_sel); end
        tick();
        for (int c = 1; c < 6; c++) begin
            set_in(4'hF, 4'h0, 1'b0);
            checks++; if (s_grant !== 4'h0) begin errors++; $display("FAIL stall grant c=%0d got=%b exp=0000", c, s_grant); end
            checks++; if (m_result_valid !== 4'h0) begin errors++; $display("FAIL stall result c=%0d got=%b exp=0000", c, m_result_valid); end
            tick();
        end
        set_in(4'hF, 4'h0, 1'b1);
        checks++; if (s_grant !== 4'b1000) begin errors++; $display("FAIL stall frozen_ptr got=%b exp=1000", s_grant); end
        tick();
        set_in(4'h0, 4'h0, 1'b1);
        checks++; if (m_result_valid !== 4'h0) begin errors++; $display("FAIL stall early_result got=%b exp=0000", m_result_valid); end
        tick();
        for (int c = 8; c < 11; c++) begin
            set_in(4'h0, 4'h0, 1'b0);
            checks++; if (m_result_valid !== 4'b0100) begin errors++; $display("FAIL stall held_result c=%0d got=%b exp=0100", c, m_result_valid); end
            tick();
        end
        set_in(4'h0, 4'h0, 1'b1);
        checks++; if (m_result_valid !== 4'b0100) begin errors++; $display("FAIL stall release_result got=%b exp=0100", m_result_valid); end
        tick();
        set_in(4'h0, 4'h0, 1'b1);
        checks++; if (m_result_valid !== 4'b1000) begin errors++; $display("FAIL stall next_result got=%b exp=1000", m_result_valid); end
        tick();
    endtask

    task automatic test_credit_error;
        do_reset();
        set_in(4'b0010, 4'h0, 1'b1);
        checks++; if (s_grant !== 4'b0010) begin errors++; $display("FAIL credit grant0 got=%b exp=0010", s_grant); end
        checks++; if (m_credit[7:4] !== 4'd2) begin errors++; $display("FAIL credit c0 got=%0d exp=2", m_credit[7:4]); end
        tick();
        set_in(4'b0010, 4'b0010, 1'b1);
        checks++; if (s_grant !== 4'b0010) begin errors++; $display("FAIL credit grant_with_ret got=%b exp=0010", s_grant); end
        checks++; if (m_credit[7:4] !== 4'd1) begin errors++; $display("FAIL credit c1 got=%0d exp=1", m_credit[7:4]); end
        tick();
        set_in(4'b0000, 4'b0010, 1'b1);
        checks++; if (m_credit[7:4] !== 4'd1) begin errors++; $display("FAIL credit unchanged got=%0d exp=1", m_credit[7:4]); end
        tick();
        set_in(4'b0000, 4'b0010, 1'b1);
        checks++; if (m_credit[7:4] !== 4'd2) begin errors++; $display("FAIL credit refill got=%0d exp=2", m_credit[7:4]); end
        checks++; if (m_error !== 1'b0) begin errors++; $display("FAIL credit error_early got=%b exp=0", m_error); end
        tick();
        set_in(4'b0000, 4'b0000, 1'b1);
        checks++; if (m_error !== 1'b1) begin errors++; $display("FAIL credit error_set got=%b exp=1", m_error); end
        checks++; if (m_credit[7:4] !== 4'd2) begin errors++; $display("FAIL credit overflow_held got=%0d exp=2", m_credit[7:4]); end
        tick();
        set_in(4'b0000, 4'b0000, 1'b0);
        checks++; if (m_error !== 1'b1) begin errors++; $display("FAIL credit error_sticky got=%b exp=1", m_error); end
        tick();
    endtask

    task automatic test_reset_midflight;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(4'hF, 4'h0, 1'b1);
            checks++; if (s_grant !== 4'(1 << c)) begin errors++; $display("FAIL midreset grant c=%0d got=%b exp=%b", c, s_grant, 4'(1 << c)); end
            if (c < 2) tick();
        end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (s_grant !== 4'h0) begin errors++; $display("FAIL midreset async_grant got=%b exp=0000", s_grant); end
        checks++; if (m_issue_valid !== 1'b0) begin errors++; $display("FAIL midreset async_issue got=%b exp=0", m_issue_valid); end
        checks++; if (m_issue_sel !== 2'd0) begin errors++; $display("FAIL midreset async_sel got=%0d exp=0", m_issue_sel); end
        tick();
        checks++; if (m_credit !== 16'h2222) begin errors++; $display("FAIL midreset credit got=%h exp=2222", m_credit); end
        checks++; if (m_result_valid !== 4'h0) begin errors++; $display("FAIL midreset result_in_reset got=%b exp=0000", m_result_valid); end
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            set_in(4'h0, 4'h0, 1'b1);
            checks++; if (m_result_valid !== 4'h0) begin errors++; $display("FAIL midreset ghost_result c=%0d got=%b exp=0000", c, m_result_valid); end
            tick();
        end
        set_in(4'b1010, 4'h0, 1'b1);
        checks++; if (s_grant !== 4'b0010) begin errors++; $display("FAIL midreset first_grant got=%b exp=0010", s_grant); end
        tick();
    endtask

    task automatic test_wraparound;
        logic [3:0] eg;
        do_reset();
        set_in(4'b0100, 4'h0, 1'b1);
        checks++; if (s_grant !== 4'b0100) begin errors++; $display("FAIL wrap setup got=%b exp=0100", s_grant); end
        tick();
        for (int c = 0; c < 3; c++) begin
            eg = (c == 1) ? 4'b0001 : 4'b1000;
            set_in(4'b1001, 4'h0, 1'b1);
            checks++; if (s_grant !== eg) begin errors++; $display("FAIL wrap grant c=%0d got=%b exp=%b", c, s_grant, eg); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cke_stall();
        test_credit_error();
        test_reset_midflight();
        test_wraparound();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spu_pipe_arbiter.md
Name: spu_pipe_arbiter

Overview:
- Shares one fixed-latency SPU compute pipeline between N requesters.
- Each cycle it grants at most one requester by round-robin and drives the operand-mux select and issue valid into the pipeline.
- It carries the grant index alongside the pipeline and routes the result valid back to the owning requester exactly LATENCY enabled cycles later.
- Per-requester credit counters bound the results in flight to each requester's result buffer.

Parameters:
N, 4, number of requesters (2..16)
LATENCY, 3, pipeline depth in cke-enabled cycles; must be >= 1 (elaboration error otherwise)
CREDITS, 2, result-buffer depth per requester; initial and maximum credit (1..15)
SEL_W, $clog2(N), width of the requester index (derived, not overridden)

Ports:
clk  in  1  clock; one clock, all logic on posedge
reset_n  in  1  reset is asynchronous and active-low
cke  in  1  clock enable for arbitration and the tag pipeline
s_req  in  N  per-requester issue request; level, held until granted
s_grant  out  N  one-hot grant, combinational; request consumed when s_grant[i] & cke
s_credit_ret  in  N  per-requester pulse; one result drained from that requester's buffer
m_issue_valid  out  1  one request issued into the pipeline this cycle
m_issue_sel  out  SEL_W  index of the granted requester (operand mux select); 0 when idle
m_result_valid  out  N  one-hot; result for requester i leaves the pipeline this cycle
m_credit  out  N*4  current credit per requester, packed; requester i at [4i+3:4i]
m_error  out  1  sticky; credit return seen while credit == CREDITS

Behaviour:
- Reset (async assert, sync release), all while reset_n=0:
  - rr_ptr = 0, every tag stage invalid.
  - Every credit = CREDITS, m_error = 0.
  - Outputs s_grant = 0, m_issue_valid = 0, m_issue_sel = 0, m_result_valid = 0.
  - Reset mid-operation discards all in-flight tags; no m_result_valid is produced for them.
- Eligibility:
  - elig[i] = s_req[i] & (credit[i] != 0).
  - When cke=0, no requester is granted (s_grant = 0).
- Arbitration (combinational):
  - Search elig from index rr_ptr upward, wrapping N-1 -> 0; the first eligible index wins.
  - s_grant = onehot(win); m_issue_valid = |s_grant; m_issue_sel = win.
- Pointer update, on a clock edge with cke=1 and an issue: rr_ptr <= (win+1) mod N. Otherwise it holds.
- Tag pipeline:
  - There are LATENCY stages of {valid, idx}.
  - Stage 1 loads {m_issue_valid, m_issue_sel} when cke=1.
  - Stage k+1 loads stage k when cke=1.
  - All stages hold when cke=0.
  - m_result_valid = stage[LATENCY].valid ? onehot(stage[LATENCY].idx) : 0. It stays asserted for as long as cke is low (mirrors the pipeline's frozen output).
- Latency: an issue on enabled edge E produces m_result_valid on the cycle after LATENCY enabled edges, aligned with the SPU datapath m_valid.
- Credits, per requester, updated every edge independent of cke:
  - Grant only: credit - 1.
  - Return only: credit + 1.
  - Grant and return in the same cycle: unchanged.
  - Return with credit == CREDITS and no grant: credit held, m_error <= 1.
  - A grant cannot occur at credit == 0 (not eligible), so there is no underflow.
- Back-to-back: the same requester may be granted on consecutive cycles only if no other requester is eligible.
- Throughput: the pipeline accepts one issue per enabled cycle; there is no bubble between grants.

Test Plan:
- Single requester, N=4, LATENCY=3, CREDITS=2. s_req=0001 held, no returns:
  - Grants on cycles 0 and 1 only; credit[0] goes 2 -> 1 -> 0.
  - m_result_valid=0001 on cycles 3 and 4.
  - Then s_credit_ret[0] pulse -> grant resumes the next cycle.
- All four requesting continuously, returns each cycle after a result:
  - Grant order 0, 1, 2, 3, 0, 1...
  - m_issue_sel sequence 0, 1, 2, 3, 0; each m_result_valid one-hot matches the issuing index 3 cycles later.
- cke stall: issue to requester 2, then cke=0 for 5 cycles after 1 enabled edge:
  - No grants and the pointer is frozen during the stall.
  - The result appears after 2 further enabled edges and holds while cke is low.
- Simultaneous grant and credit return for requester 1 at credit=1:
  - Credit stays 1 and the grant proceeds.
  - A return at credit=2 with no grant -> m_error=1 and stays 1.
- Reset mid-flight: 3 issues outstanding, reset_n low 1 cycle:
  - All outputs are 0 immediately (asynchronously).
  - No m_result_valid ever appears for those issues.
  - Credits are 2 and the first grant after release goes to the lowest requesting index.
- Wrap-around: rr_ptr=3 with s_req=1001 -> grant 3, then grant 0, then grant 3.
